// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and data-memory bus bundle for lsu_ctrl.
// master: the controller's view. slave: the view of whatever surrounds it
// (the core's memory stage plus the data memory).
interface lsu_ctrl_if;
  // core request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // core response
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // data memory bus
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rsp_ready,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rsp_ready,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one access at a time, alignment/funct3 checking,
// byte-enable and store-lane generation, variable-latency bus handshake with
// timeout, and sign/zero-extended load return.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255   // 1..255 cycles in REQ+WAIT
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  // Counter value seen in the last permitted REQ/WAIT cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        legal, misal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] lane, ld_data;

  // Decode the live request: legality, alignment, byte enables, store lanes.
  always_comb begin
    legal     = 1'b0;
    misal     = 1'b0;
    be_new    = 4'b1111;
    wdata_new = '0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !bus.req_we;
      default:                legal = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'b00: begin
        be_new = 4'b0001 << bus.req_addr[1:0];
        if (bus.req_we) wdata_new = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        misal  = bus.req_addr[0];
        be_new = 4'b0011 << {bus.req_addr[1], 1'b0};
        if (bus.req_we) wdata_new = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        misal  = (bus.req_addr[1:0] != 2'b00);
        be_new = 4'b1111;
        if (bus.req_we) wdata_new = bus.req_wdata;
      end
    endcase
  end

  // Shift the addressed byte/halfword down to bit 0 and extend per funct3.
  always_comb begin
    lane = bus.mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b010:  ld_data = bus.mem_rdata;
      3'b100:  ld_data = {24'b0, lane[7:0]};
      3'b101:  ld_data = {16'b0, lane[15:0]};
      default: ld_data = '0;
    endcase
  end

  // Next-state and datapath capture. Completion is tested before the
  // timeout so a response arriving on the last allowed cycle is not an error.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d  = bus.req_we;
          f3_d  = bus.req_funct3;
          off_d = bus.req_addr[1:0];
          if (!legal || misal) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = S_RESP;
          end else begin
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
            cnt_d       = '0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt && we_q) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (bus.mem_gnt && bus.mem_rvalid) begin
          rsp_rdata_d = ld_data;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (bus.mem_gnt) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          rsp_rdata_d = ld_data;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_req   = (state_q == S_REQ);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes model expectations, a
// negedge monitor checks the memory bus and pops/compares responses.
module tb_lsu_ctrl;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();
  lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          req_cycles = 0;
  int          hold_lo = 0;
  bit          mon_en = 1'b0;
  logic        exp_mem_active = 1'b0;
  logic        exp_we = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: bytes covered are [off, off+size); store byte i carries store
  // byte (i mod size); loads pick the addressed bytes and extend arithmetically.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output bit bad, output logic [3:0] be,
                                output logic [31:0] mwd, output logic [31:0] rdata);
    int size, off;
    logic [31:0] lane;
    longint v;
    off = int'(addr % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd3) || ((off % size) != 0);
    be = '0;
    mwd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) be[i] = 1'b1;
      if (we) mwd[8*i +: 8] = wd[8*(i % size) +: 8];
    end
    lane = rd >> (8 * off);
    v = 0;
    case (f3)
      3'd0: begin v = lane % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = lane % 65536; if (v >= 32768) v = v - 65536; end
      3'd2: v = rd;
      3'd4: v = lane % 256;
      3'd5: v = lane % 65536;
      default: v = 0;
    endcase
    rdata = we ? 32'd0 : v[31:0];
  endfunction

  task automatic wait_accept(output bit acc, output int acc_c);
    int n;
    acc = 1'b0;
    acc_c = 0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.req_ready;
      acc_c = cyc;
      @(posedge clk); #1;
      n++;
    end
    bus.req_valid = 1'b0;
    // scramble request fields: they must be ignored outside IDLE
    bus.req_addr = $urandom;
    bus.req_wdata = $urandom;
    bus.req_funct3 = 3'($urandom_range(0, 7));
    bus.req_we = 1'($urandom_range(0, 1));
    if (!acc) chk("accept_timeout", {63'd0, acc}, 64'd1);
  endtask

  // g: REQ cycle index carrying mem_gnt; r: extra cycles from gnt to rvalid.
  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int g, input int r, input logic [31:0] rd);
    bit bad, acc;
    logic [3:0] be;
    logic [31:0] mwd, erd;
    exp_t e;
    int done, last, acc_c;
    model(we, f3, addr, wd, rd, bad, be, mwd, erd);
    exp_we = we;
    exp_addr = addr & ~32'd3;
    exp_be = be;
    exp_wdata = mwd;
    exp_mem_active = !bad;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    wait_accept(acc, acc_c);
    if (!acc) begin exp_mem_active = 1'b0; return; end
    req_cycles = 0;
    e.acc_cyc = acc_c;
    if (bad) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 1;
      exp_q.push_back(e);
      hold_lo = 5;
      repeat (2) begin @(posedge clk); #1; end
      chk("err_req_cycles", req_cycles, 0);
      return;
    end
    done = we ? g : g + r;
    last = (done < TO) ? done : TO - 1;
    e.err = (done >= TO);
    e.rdata = e.err ? 32'd0 : erd;
    e.lat = last + 2;
    exp_q.push_back(e);
    for (int k = 0; k <= last; k++) begin
      bus.mem_gnt = (k == g);
      bus.mem_rvalid = !we && (k == g + r);
      bus.mem_rdata = (k == g + r) ? rd : $urandom;
      @(posedge clk); #1;
    end
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = $urandom;
    chk("req_cycles", req_cycles, ((g < last) ? g : last) + 1);
    exp_mem_active = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1;
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    end
  endtask

  task automatic reset_in_wait();
    bit acc;
    int acc_c;
    exp_we = 1'b0; exp_addr = 32'h100; exp_be = 4'hF; exp_wdata = '0;
    exp_mem_active = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h100; bus.req_wdata = $urandom;
    wait_accept(acc, acc_c);
    bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_mem_active = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
      chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
      chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    end
    @(posedge clk); #1;
  endtask

  // Response sink: random backpressure, or forced low for a stall window.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (hold_lo > 0) begin bus.rsp_ready = 1'b0; hold_lo--; end
      else bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: memory bus against the pending access, responses against queue.
  initial begin
    bit pv, pr;
    exp_t e;
    pv = 1'b0; pr = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.mem_req) begin
          req_cycles++;
          chk("mem_req_expected", {63'd0, bus.mem_req}, {63'd0, exp_mem_active});
          if (exp_mem_active) begin
            chk("mem_we_be_addr", {27'd0, bus.mem_we, bus.mem_be, bus.mem_addr},
                {27'd0, exp_we, exp_be, exp_addr});
            chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, exp_wdata});
          end
        end
        if (pv && !pr) chk("rsp_held", {63'd0, bus.rsp_valid}, 64'd1);
        if (bus.rsp_valid) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", {63'd0, bus.rsp_valid}, 64'd0);
          else begin
            e = exp_q[0];
            if (!pv) chk("latency", cyc - e.acc_cyc, e.lat);
            chk("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e.rdata});
            chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e.err});
            chk("req_ready_in_resp", {63'd0, bus.req_ready}, 64'd0);
            if (bus.rsp_ready) void'(exp_q.pop_front());
          end
        end
        pv = bus.rsp_valid;
        pr = bus.rsp_ready;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit we, acc_ok;
    logic [2:0] f3;
    logic [31:0] addr;
    int g, r, n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("reset_rsp", {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 64'd0);
    chk("reset_mem_ctl", {58'd0, bus.mem_req, bus.mem_we, bus.mem_be}, 64'd0);
    chk("reset_mem_addr", {32'd0, bus.mem_addr}, 64'd0);
    chk("reset_mem_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);   // LB
    do_access(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 32'h80FF_1234);   // LBU
    do_access(1'b0, 3'd5, 32'h102, 32'h0, 3, 2, 32'h80FF_1234);   // LHU
    do_access(1'b0, 3'd1, 32'h102, 32'h0, 3, 2, 32'h80FF_1234);   // LH
    do_access(1'b1, 3'd0, 32'h101, 32'h1234_56A5, 1, 0, 32'h0);   // SB
    do_access(1'b1, 3'd1, 32'h102, 32'h1234_56A5, 0, 0, 32'h0);   // SH
    do_access(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 2, 0, 32'h0);   // SW
    do_access(1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 32'h0);           // LW misaligned
    do_access(1'b1, 3'd1, 32'h103, 32'h0, 0, 0, 32'h0);           // SH misaligned
    do_access(1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 32'h0);           // illegal load
    do_access(1'b1, 3'd4, 32'h100, 32'h0, 0, 0, 32'h0);           // illegal store
    do_access(1'b0, 3'd2, 32'h40, 32'h0, 100, 0, 32'h1);          // no gnt
    do_access(1'b0, 3'd2, 32'h40, 32'h0, 1, 100, 32'h1);          // gnt, no rvalid
    do_access(1'b0, 3'd2, 32'h40, 32'h0, 3, 4, 32'h7777_1111);    // done on last cycle
    do_access(1'b1, 3'd2, 32'h44, 32'h5, 7, 0, 32'h0);            // store gnt on last cycle
    reset_in_wait();
    do_access(1'b0, 3'd2, 32'h200, 32'h0, 0, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end else f3 = 3'($urandom_range(0, 7));
      g = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      r = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      do_access(we, f3, addr, $urandom, g, r, $urandom);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    acc_ok = (exp_q.size() == 0);
    chk("drain", {63'd0, acc_ok}, 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
